// File: rtl/cmd_frame_scheduler.sv
// -----------------------------------------------------------------------------
// cmd_frame_scheduler
//
// Purpose:
//   Arbitrates round-robin between a write-request source and a read-request
//   source that share one command encoder. The winning request is registered
//   onto the encoder inputs. One cycle later the 56-bit encoded command
//   (8-bit header + 48-bit payload) is captured into a shift register. The
//   command is then streamed MSB byte first to the UART transmitter over a
//   valid/ready byte interface.
//
// Ports:
//   clk, rst_n                  system clock (rising edge), async active-low reset
//   wr_req_valid/data/ready     write request handshake (48-bit payload)
//   rd_req_valid/data/ready     read request handshake (48-bit payload)
//   enc_req, enc_wr             registered payload and write flag to the encoder
//   enc_cmd                     combinational encoder result for enc_req/enc_wr
//   tx_data, tx_valid, tx_ready byte stream to the UART transmitter
//   busy                        high whenever a frame is in flight
//   cmd_done                    one-cycle pulse after the last byte handshake
// -----------------------------------------------------------------------------
module cmd_frame_scheduler #(
    parameter int REQ_W     = 48,
    parameter int CMD_W     = REQ_W + 8,
    parameter int NUM_BYTES = CMD_W / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req_valid,
    input  logic [REQ_W-1:0] wr_req_data,
    output logic             wr_req_ready,
    input  logic             rd_req_valid,
    input  logic [REQ_W-1:0] rd_req_data,
    output logic             rd_req_ready,
    output logic [REQ_W-1:0] enc_req,
    output logic             enc_wr,
    input  logic [CMD_W-1:0] enc_cmd,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             cmd_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);

    // last_grant encoding: 1 = write won last, 0 = read won last.
    localparam logic GRANT_WR = 1'b1;
    localparam logic GRANT_RD = 1'b0;

    logic [1:0]       state_q,      state_d;
    logic [REQ_W-1:0] enc_req_q,    enc_req_d;
    logic             enc_wr_q,     enc_wr_d;
    logic [CMD_W-1:0] shift_q,      shift_d;
    logic [2:0]       byte_cnt_q,   byte_cnt_d;
    logic             last_grant_q, last_grant_d;

    logic grant_wr;
    logic grant_rd;

    // Round-robin arbitration: on a tie the source that did not win last time
    // gets the encoder. Reset leaves last_grant at READ so writes win first.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state_q == IDLE) begin
            if (wr_req_valid && rd_req_valid) begin
                grant_wr = (last_grant_q == GRANT_RD);
                grant_rd = (last_grant_q == GRANT_WR);
            end else begin
                grant_wr = wr_req_valid;
                grant_rd = rd_req_valid;
            end
        end
    end

    // Readies are gated by rst_n so no request is accepted while reset is held.
    assign wr_req_ready = rst_n && grant_wr;
    assign rd_req_ready = rst_n && grant_rd;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        enc_req_d    = enc_req_q;
        enc_wr_d     = enc_wr_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (grant_wr || grant_rd) begin
                    enc_req_d    = grant_wr ? wr_req_data : rd_req_data;
                    enc_wr_d     = grant_wr;
                    last_grant_d = grant_wr ? GRANT_WR : GRANT_RD;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                // The encoder output has now settled on the registered request.
                shift_d    = enc_cmd;
                byte_cnt_d = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    shift_d = shift_q << 8;
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Hold the count at the last index instead of wrapping.
                        state_d = DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            enc_req_q    <= '0;
            enc_wr_q     <= 1'b0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            last_grant_q <= GRANT_RD;
        end else begin
            state_q      <= state_d;
            enc_req_q    <= enc_req_d;
            enc_wr_q     <= enc_wr_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs decode directly from registers. An asynchronous reset therefore
    // drops tx_valid and busy at once, without waiting for a clock edge.
    assign enc_req  = enc_req_q;
    assign enc_wr   = enc_wr_q;
    assign tx_valid = (state_q == SEND);
    assign tx_data  = shift_q[CMD_W-1 -: 8];
    assign busy     = (state_q != IDLE);
    assign cmd_done = (state_q == DONE);

endmodule

// File: doc/cmd_frame_scheduler.md
Name: cmd_frame_scheduler

Overview:
- Arbitrates between a write-request source and a read-request source sharing one command encoder.
- Drives the encoder with the winning 48-bit request and its write/read flag, then captures the resulting 56-bit command (8-bit header + 48-bit payload).
- Streams the command MSB byte first to the UART transmitter over a valid/ready byte interface.
- Sits between the host-side request logic and the UART TX in the UART-to-APB bridge.

Parameters:
- REQ_W, 48, request payload width in bits.
- CMD_W, 56, encoded command width (REQ_W + 8 header bits).
- NUM_BYTES, 7, bytes per frame (CMD_W/8).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_req_valid  input  1  write requester has a request.
- wr_req_data  input  48  write request payload.
- wr_req_ready  output  1  write request accepted this cycle when valid&ready.
- rd_req_valid  input  1  read requester has a request.
- rd_req_data  input  48  read request payload.
- rd_req_ready  output  1  read request accepted this cycle when valid&ready.
- enc_req  output  48  registered payload to encoder.
- enc_wr  output  1  registered flag to encoder: 1=write, 0=read.
- enc_cmd  input  56  encoder output, combinational from enc_req/enc_wr.
- tx_data  output  8  byte to UART TX.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART TX can take a byte.
- busy  output  1  high whenever state != IDLE.
- cmd_done  output  1  one-cycle pulse after last byte handshake.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, enc_req=0, enc_wr=0, shift register=0, byte_cnt=0, tx_valid=0, tx_data=0, cmd_done=0, last_grant=READ (write wins first tie). wr_req_ready/rd_req_ready=0 while rst_n=0.
- States: IDLE, LOAD, SEND, DONE.
- IDLE arbitration (combinational): only wr_req_valid -> grant WR; only rd_req_valid -> grant RD; both -> grant the one opposite last_grant (round-robin); neither -> no grant.
- wr_req_ready = (state==IDLE) && grant==WR; rd_req_ready likewise. Both readys are never high together.
- On handshake: enc_req <= granted data; enc_wr <= 1 for WR, 0 for RD; last_grant <= granted; go LOAD.
- LOAD (1 cycle): shift <= enc_cmd; byte_cnt <= 0; go SEND. enc_req/enc_wr hold until the next accept.
- SEND: tx_valid=1, tx_data=shift[55:48].
  - On tx_valid&&tx_ready: shift <= shift<<8; byte_cnt++.
  - If byte_cnt==NUM_BYTES-1 at handshake, go DONE.
  - tx_data/tx_valid are stable while tx_ready=0; tx_valid is never withdrawn mid-frame.
- DONE (1 cycle): cmd_done=1, tx_valid=0; go IDLE.
- Latency: accept at cycle N; LOAD at N+1; first byte tx_valid at N+2. With tx_ready held high, 7 bytes occupy N+2..N+8, cmd_done at N+9, next accept possible at N+10.
- Byte order: header (0x02 write / 0x03 read), then payload bits [47:40] down to [7:0].
- Requests arriving while busy are not accepted; ready stays low and requesters hold valid.
- byte_cnt is 3 bits and never wraps past 6.
- Reset asserted mid-frame aborts immediately: tx_valid drops asynchronously and the partial frame is discarded. After release the block is in IDLE with write priority.

Test Plan:
- Single write, wr_req_data=0x1234_DEADBEEF, tx_ready=1 -> wr_req_ready pulse at N, tx bytes 02 12 34 DE AD BE EF on cycles N+2..N+8, cmd_done at N+9, enc_wr=1.
- Single read, rd_req_data=0x00A0_00000000 -> header 0x03, then 00 A0 00 00 00 00, enc_wr=0.
- Both valid continuously after reset -> grants alternate W, R, W, R; each frame is complete and contiguous with no interleaving.
- Backpressure: tx_ready low for 5 cycles on byte 3 -> tx_valid stays 1 and tx_data holds 0x34 (write case above); the frame resumes intact and cmd_done is delayed by 5 cycles.
- rst_n pulsed low during byte 4 -> tx_valid=0 and busy=0 immediately; after release a pending read is granted and sends a full 7-byte frame from its header.
- wr_req_valid asserted while busy -> wr_req_ready stays 0 until IDLE, then accepted on the first IDLE cycle.
